// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache frame layout and address split for the
// default 16-frame configuration.
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;

    typedef struct packed {
        logic        valid;
        logic [25:0] tag;
        logic [31:0] data;
    } icache_frame_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_fetch_unit.sv
// Direct-mapped, one-word-per-block instruction cache. Hits are served
// combinationally; a miss issues one word fill and waits for the controller.
module icache_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = ICACHE_SETS,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {IDLE, FETCH} icache_state_t;

    icache_state_t     state_q, state_d;
    logic [29:0]       miss_addr_q, miss_addr_d;
    logic              valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS];
    logic [31:0]       data_q  [SETS];
    logic [31:0]       hit_count_q, miss_count_q;

    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic              fill_en, miss_start;
    logic              unused_bytoff;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign miss_idx      = miss_addr_q[IDX_W-1:0];
    assign miss_tag      = miss_addr_q[29:IDX_W];
    assign unused_bytoff = ^imemaddr[1:0];

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Outputs are gated with RST so nothing leaks to the datapath while reset
    // is held, even though the array is only cleared at the edge.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        imemload    = 32'd0;
        iREN        = 1'b0;
        iaddr       = 32'd0;
        fill_en     = 1'b0;
        miss_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && !RST) begin
                    if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = data_q[req_idx];
                    end else begin
                        miss_start  = 1'b1;
                        miss_addr_d = imemaddr[31:2];
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!RST) begin
                    iREN  = 1'b1;
                    iaddr = {miss_addr_q, 2'b00};
                end
                // The fill always lands at the latched address; a redirect
                // is picked up only once we are back in IDLE.
                if (!iwait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= 30'd0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill_en) begin
                valid_q[miss_idx] <= 1'b1;
                tag_q[miss_idx]   <= miss_tag;
                data_q[miss_idx]  <= iload;
            end
            if (ihit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Bench for icache_fetch_unit: directed test-plan steps followed by random
// traffic, all checked against a word-level cache/memory reference model.
module tb_icache_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int cmp_count = 0;
    int err_count = 0;

    // Reference model: instruction memory, 16 direct-mapped frames,
    // one outstanding fill and the two performance counters.
    logic [31:0] mem [logic [29:0]];
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16];
    bit          pending;
    logic [31:0] pend_addr;
    logic [31:0] m_hits, m_misses;

    icache_fetch_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .imemload   (imemload),
        .ihit       (ihit),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [29:0] w;
        w = addr[31:2];
        if (!mem.exists(w)) mem[w] = $urandom;
        return mem[w];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        int unsigned set_no;
        set_no = (addr / 4) % 16;
        return m_valid[set_no] && (m_tag[set_no] == addr / 64);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        assert (obs === exp)
        else begin
            err_count++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        pending  = 1'b0;
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cyc(input logic rst, input logic ren, input logic [31:0] addr, input logic wt);
        bit          exp_hit;
        bit          exp_ren;
        int unsigned set_no;
        RST      = rst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = (pending && !wt) ? mem_word(pend_addr) : $urandom;
        @(negedge CLK);
        exp_ren = !rst && pending;
        exp_hit = !rst && !pending && ren && model_hit(addr);
        check("ihit",       {31'd0, ihit}, {31'd0, exp_hit});
        check("imemload",   imemload, exp_hit ? mem_word(addr) : 32'd0);
        check("iREN",       {31'd0, iREN}, {31'd0, exp_ren});
        check("iaddr",      iaddr, exp_ren ? {pend_addr[31:2], 2'b00} : 32'd0);
        check("hit_count",  hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else if (pending) begin
            if (!wt) begin
                set_no          = (pend_addr / 4) % 16;
                m_valid[set_no] = 1'b1;
                m_tag[set_no]   = pend_addr / 64;
                m_data[set_no]  = mem_word(pend_addr);
                pending         = 1'b0;
            end
        end else if (ren) begin
            if (exp_hit) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
            end else begin
                pending   = 1'b1;
                pend_addr = addr;
                if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] a;
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;
        model_reset();
        mem[30'h10] = 32'h2008_0001;
        mem[30'h20] = 32'hAAAA_AAAA;
        @(posedge CLK);
        #1;

        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h40, 1'b0);
        check("reset_hits",   hit_count,  32'd0);
        check("reset_misses", miss_count, 32'd0);

        // Cold miss with three wait cycles, then five hits.
        cyc(1'b0, 1'b1, 32'h40, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 32'h40, 1'b1);
        cyc(1'b0, 1'b1, 32'h40, 1'b0);
        repeat (5) cyc(1'b0, 1'b1, 32'h40, 1'b1);
        check("cold_hits",   hit_count,  32'd5);
        check("cold_misses", miss_count, 32'd1);

        // Conflict on frame 0: 0x80 evicts 0x40.
        cyc(1'b0, 1'b1, 32'h80, 1'b1);
        cyc(1'b0, 1'b1, 32'h80, 1'b0);
        cyc(1'b0, 1'b1, 32'h80, 1'b1);
        cyc(1'b0, 1'b1, 32'h40, 1'b1);
        cyc(1'b0, 1'b1, 32'h40, 1'b0);
        check("conflict_misses", miss_count, 32'd3);

        // Byte offset ignored on hit and on miss address.
        cyc(1'b0, 1'b1, 32'h43, 1'b1);
        cyc(1'b0, 1'b1, 32'h2C7, 1'b1);
        cyc(1'b0, 1'b1, 32'h2C7, 1'b0);
        cyc(1'b0, 1'b1, 32'h2C5, 1'b1);

        // Redirect and halt during a fill.
        cyc(1'b0, 1'b1, 32'h100, 1'b1);
        cyc(1'b0, 1'b1, 32'h104, 1'b1);
        cyc(1'b0, 1'b0, 32'h104, 1'b1);
        cyc(1'b0, 1'b1, 32'h104, 1'b0);
        cyc(1'b0, 1'b1, 32'h104, 1'b1);
        cyc(1'b0, 1'b1, 32'h104, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 1'b1);

        // Reset in the same cycle a fill completes: the fill is dropped.
        cyc(1'b0, 1'b1, 32'h208, 1'b1);
        cyc(1'b0, 1'b1, 32'h208, 1'b1);
        cyc(1'b1, 1'b1, 32'h208, 1'b0);
        check("rstfill_hits",   hit_count,  32'd0);
        check("rstfill_misses", miss_count, 32'd0);
        cyc(1'b0, 1'b1, 32'h208, 1'b1);
        cyc(1'b0, 1'b1, 32'h208, 1'b0);
        cyc(1'b0, 1'b1, 32'h208, 1'b1);
        cyc(1'b0, 1'b0, 32'h40, 1'b1);

        // Random traffic over a small address pool to force hits and conflicts.
        for (int n = 0; n < 800; n++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                a,
                ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
